// File: rtl/array_alloc_arbiter.sv
// array_alloc_arbiter: round-robin front end sharing the heap array allocator
// (allocs counter + freed-array LIFO) between NReq requesters.
`default_nettype none

module array_alloc_arbiter #(
   parameter int MemoryElementWidth = 12,
   parameter int NArrays            = 2,
   parameter int NReq               = 2
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NReq-1:0]                    req_valid,
   input  logic [NReq-1:0]                    req_free,
   input  logic [NReq*MemoryElementWidth-1:0] req_array,
   output logic [NReq-1:0]                    ack,
   output logic [MemoryElementWidth-1:0]      ack_array,
   output logic                               ack_error,
   output logic                               size_clear,
   output logic [MemoryElementWidth-1:0]      size_index,
   output logic [MemoryElementWidth-1:0]      in_use,
   output logic [MemoryElementWidth-1:0]      high_water
);

   localparam int c_rr_w = (NReq > 1) ? $clog2(NReq) : 1;
   localparam logic [MemoryElementWidth-1:0] c_narrays = MemoryElementWidth'(NArrays);
   localparam logic [MemoryElementWidth-1:0] c_one     = MemoryElementWidth'(1);

   typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

   state_t                         r_state;
   logic [c_rr_w-1:0]              r_rr;
   logic [c_rr_w-1:0]              r_gnt;
   logic                           r_free;
   logic [MemoryElementWidth-1:0]  r_arr;
   logic [MemoryElementWidth-1:0]  r_allocs;
   logic [MemoryElementWidth-1:0]  r_top;
   logic [NArrays-1:0]             r_bitmap;
   logic [MemoryElementWidth-1:0]  r_stack [NArrays];

   logic                           w_found;
   logic [c_rr_w-1:0]              w_pick;
   logic                           w_pick_free;
   logic [MemoryElementWidth-1:0]  w_pick_arr;
   logic [NReq-1:0]                w_gnt_hot;
   logic [c_rr_w-1:0]              w_rr_next;
   logic [MemoryElementWidth-1:0]  w_top_m1;
   logic [MemoryElementWidth-1:0]  w_popped;
   logic                           w_live;
   logic                           w_alloc_ok;
   logic [MemoryElementWidth-1:0]  w_alloc_val;
   logic                           w_free_ok;

   // First asserted requester at or after the round-robin pointer, wrapping at NReq.
   always_comb begin
      w_found     = 1'b0;
      w_pick      = '0;
      w_pick_free = 1'b0;
      w_pick_arr  = '0;
      for (int k = 0; k < NReq; k++) begin
         for (int j = 0; j < NReq; j++) begin
            if (!w_found && req_valid[j] && (j == ((int'(r_rr) + k) % NReq))) begin
               w_found     = 1'b1;
               w_pick      = c_rr_w'(j);
               w_pick_free = req_free[j];
               w_pick_arr  = req_array[j*MemoryElementWidth +: MemoryElementWidth];
            end
         end
      end
   end

   always_comb begin
      w_gnt_hot = '0;
      for (int i = 0; i < NReq; i++) begin
         w_gnt_hot[i] = (c_rr_w'(i) == r_gnt);
      end
      w_rr_next = (r_gnt == c_rr_w'(NReq - 1)) ? '0 : r_gnt + c_rr_w'(1);
   end

   // Stack top and bitmap lookups; an out-of-range array simply reads as not live.
   always_comb begin
      w_top_m1 = r_top - c_one;
      w_popped = '0;
      w_live   = 1'b0;
      for (int i = 0; i < NArrays; i++) begin
         if (MemoryElementWidth'(i) == w_top_m1) w_popped = r_stack[i];
         if (MemoryElementWidth'(i) == r_arr)    w_live   = r_bitmap[i];
      end
      w_alloc_ok  = (r_top != '0) || (r_allocs < c_narrays);
      w_alloc_val = (r_top != '0) ? w_popped : r_allocs;
      w_free_ok   = (r_arr < r_allocs) && w_live;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_rr       <= '0;
         r_gnt      <= '0;
         r_free     <= 1'b0;
         r_arr      <= '0;
         r_allocs   <= '0;
         r_top      <= '0;
         r_bitmap   <= '0;
         for (int i = 0; i < NArrays; i++) r_stack[i] <= '0;
         ack        <= '0;
         ack_array  <= '0;
         ack_error  <= 1'b0;
         size_clear <= 1'b0;
         size_index <= '0;
         in_use     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt   <= w_pick;
                  r_free  <= w_pick_free;
                  r_arr   <= w_pick_arr;
                  r_state <= SERVE;
               end
            end
            SERVE: begin
               ack     <= w_gnt_hot;
               r_state <= DONE;
               if (!r_free) begin
                  if (w_alloc_ok) begin
                     if (r_top != '0) r_top    <= w_top_m1;
                     else             r_allocs <= r_allocs + c_one;
                     for (int i = 0; i < NArrays; i++) begin
                        if (MemoryElementWidth'(i) == w_alloc_val) r_bitmap[i] <= 1'b1;
                     end
                     in_use     <= in_use + c_one;
                     ack_array  <= w_alloc_val;
                     size_clear <= 1'b1;
                     size_index <= w_alloc_val;
                  end else begin
                     ack_error <= 1'b1;
                  end
               end else begin
                  if (w_free_ok) begin
                     for (int i = 0; i < NArrays; i++) begin
                        if (MemoryElementWidth'(i) == r_top) r_stack[i]  <= r_arr;
                        if (MemoryElementWidth'(i) == r_arr) r_bitmap[i] <= 1'b0;
                     end
                     r_top  <= r_top + c_one;
                     in_use <= in_use - c_one;
                  end else begin
                     ack_error <= 1'b1;
                  end
               end
            end
            DONE: begin
               ack        <= '0;
               ack_array  <= '0;
               ack_error  <= 1'b0;
               size_clear <= 1'b0;
               size_index <= '0;
               r_rr       <= w_rr_next;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign high_water = r_allocs;

endmodule

`default_nettype wire

// File: tb/tb_array_alloc_arbiter.sv
// tb_array_alloc_arbiter: directed scenario bench for array_alloc_arbiter (NArrays=2, NReq=2).
`default_nettype none

module tb_array_alloc_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_free;
   logic [23:0] req_array;
   logic [1:0]  ack;
   logic [11:0] ack_array;
   logic        ack_error;
   logic        size_clear;
   logic [11:0] size_index;
   logic [11:0] in_use;
   logic [11:0] high_water;

   int n_checks = 0;
   int n_fail   = 0;

   array_alloc_arbiter #(
      .MemoryElementWidth(12),
      .NArrays           (2),
      .NReq              (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_free   (req_free),
      .req_array  (req_array),
      .ack        (ack),
      .ack_array  (ack_array),
      .ack_error  (ack_error),
      .size_clear (size_clear),
      .size_index (size_index),
      .in_use     (in_use),
      .high_water (high_water)
   );

   always #5 clock = ~clock;

   // Single-requester operation: returns what was seen in the ack cycle and the
   // number of clock edges from request to ack (-1 if no ack arrived).
   task automatic run_op(input int r, input logic fr, input logic [11:0] arr,
                         output logic [1:0] got_ack, output logic [11:0] got_arr,
                         output logic got_err, output logic got_clr,
                         output logic [11:0] got_idx, output int lat);
      req_valid[r] = 1'b1;
      req_free[r]  = fr;
      req_array[r*12 +: 12] = arr;
      lat = -1;
      got_ack = '0; got_arr = '0; got_err = 1'b0; got_clr = 1'b0; got_idx = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clock); #1;
         if (ack != 2'b00) begin
            lat = c; got_ack = ack; got_arr = ack_array; got_err = ack_error;
            got_clr = size_clear; got_idx = size_index;
            break;
         end
      end
      req_valid[r] = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0; req_free = '0; req_array = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if ({ack, ack_array, ack_error, size_clear, size_index, in_use, high_water} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ack=%b arr=%0d err=%b clr=%b idx=%0d in_use=%0d hw=%0d, required all 0",
                  ack, ack_array, ack_error, size_clear, size_index, in_use, high_water);
      end
   endtask

   task automatic test_alloc();
      logic [1:0] a; logic [11:0] arr, idx; logic err, clr; int lat;
      for (int n = 0; n < 2; n++) begin
         run_op(0, 1'b0, 12'd0, a, arr, err, clr, idx, lat);
         n_checks++;
         if (a !== 2'b01 || lat !== 2 || arr !== 12'(n) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_%0d: ack=%b lat=%0d arr=%0d err=%b, required ack=01 lat=2 arr=%0d err=0",
                     n, a, lat, arr, err, n);
         end
         n_checks++;
         if (clr !== 1'b1 || idx !== 12'(n)) begin
            n_fail++;
            $display("FAIL alloc_clear_%0d: clr=%b idx=%0d, required clr=1 idx=%0d", n, clr, idx, n);
         end
      end
      n_checks++;
      if (high_water !== 12'd2 || in_use !== 12'd2) begin
         n_fail++;
         $display("FAIL alloc_counts: hw=%0d in_use=%0d, required hw=2 in_use=2", high_water, in_use);
      end
   endtask

   task automatic test_exhaust();
      logic [1:0] a; logic [11:0] arr, idx; logic err, clr; int lat;
      run_op(0, 1'b0, 12'd0, a, arr, err, clr, idx, lat);
      n_checks++;
      if (a !== 2'b01 || err !== 1'b1 || clr !== 1'b0 || arr !== 12'd0) begin
         n_fail++;
         $display("FAIL exhaust: ack=%b err=%b clr=%b arr=%0d, required ack=01 err=1 clr=0 arr=0",
                  a, err, clr, arr);
      end
      n_checks++;
      if (high_water !== 12'd2 || in_use !== 12'd2) begin
         n_fail++;
         $display("FAIL exhaust_counts: hw=%0d in_use=%0d, required hw=2 in_use=2", high_water, in_use);
      end
   endtask

   task automatic test_lifo();
      logic [1:0] a; logic [11:0] arr, idx; logic err, clr; int lat;
      run_op(0, 1'b1, 12'd1, a, arr, err, clr, idx, lat);
      n_checks++;
      if (err !== 1'b0 || arr !== 12'd0 || clr !== 1'b0 || in_use !== 12'd1) begin
         n_fail++;
         $display("FAIL free_1: err=%b arr=%0d clr=%b in_use=%0d, required err=0 arr=0 clr=0 in_use=1",
                  err, arr, clr, in_use);
      end
      run_op(0, 1'b1, 12'd0, a, arr, err, clr, idx, lat);
      n_checks++;
      if (err !== 1'b0 || in_use !== 12'd0) begin
         n_fail++;
         $display("FAIL free_0: err=%b in_use=%0d, required err=0 in_use=0", err, in_use);
      end
      run_op(0, 1'b0, 12'd0, a, arr, err, clr, idx, lat);
      n_checks++;
      if (err !== 1'b0 || arr !== 12'd0 || idx !== 12'd0 || clr !== 1'b1) begin
         n_fail++;
         $display("FAIL lifo_first: err=%b arr=%0d idx=%0d clr=%b, required err=0 arr=0 idx=0 clr=1",
                  err, arr, idx, clr);
      end
      run_op(0, 1'b0, 12'd0, a, arr, err, clr, idx, lat);
      n_checks++;
      if (err !== 1'b0 || arr !== 12'd1 || idx !== 12'd1) begin
         n_fail++;
         $display("FAIL lifo_second: err=%b arr=%0d idx=%0d, required err=0 arr=1 idx=1", err, arr, idx);
      end
      n_checks++;
      if (high_water !== 12'd2 || in_use !== 12'd2) begin
         n_fail++;
         $display("FAIL lifo_counts: hw=%0d in_use=%0d, required hw=2 in_use=2", high_water, in_use);
      end
   endtask

   task automatic test_double_free();
      logic [1:0] a; logic [11:0] arr, idx; logic err, clr; int lat;
      run_op(1, 1'b1, 12'd1, a, arr, err, clr, idx, lat);
      n_checks++;
      if (a !== 2'b10 || err !== 1'b0 || in_use !== 12'd1) begin
         n_fail++;
         $display("FAIL dfree_first: ack=%b err=%b in_use=%0d, required ack=10 err=0 in_use=1", a, err, in_use);
      end
      run_op(1, 1'b1, 12'd1, a, arr, err, clr, idx, lat);
      n_checks++;
      if (a !== 2'b10 || err !== 1'b1 || in_use !== 12'd1) begin
         n_fail++;
         $display("FAIL dfree_second: ack=%b err=%b in_use=%0d, required ack=10 err=1 in_use=1", a, err, in_use);
      end
      run_op(1, 1'b1, 12'd5, a, arr, err, clr, idx, lat);
      n_checks++;
      if (err !== 1'b1 || in_use !== 12'd1 || high_water !== 12'd2) begin
         n_fail++;
         $display("FAIL free_range: err=%b in_use=%0d hw=%0d, required err=1 in_use=1 hw=2",
                  err, in_use, high_water);
      end
   endtask

   // Both requesters issue the same op together; acks must alternate 0 then 1,
   // on edges 2 and 5 after the requests go up.
   task automatic test_rr();
      logic [1:0] got [2];
      logic [11:0] got_arr [2];
      logic        got_err [2];
      int          edge_at [2];
      int          seen;
      do_reset();
      for (int round = 0; round < 2; round++) begin
         req_valid = 2'b11;
         req_free  = (round == 0) ? 2'b00 : 2'b11;
         req_array = {12'd1, 12'd0};
         seen = 0;
         edge_at[0] = -1; edge_at[1] = -1;
         got[0] = '0; got[1] = '0;
         got_arr[0] = '0; got_arr[1] = '0; got_err[0] = 1'b0; got_err[1] = 1'b0;
         for (int c = 1; c <= 20 && seen < 2; c++) begin
            @(posedge clock); #1;
            if (ack != 2'b00) begin
               got[seen] = ack; got_arr[seen] = ack_array; got_err[seen] = ack_error;
               edge_at[seen] = c;
               req_valid = req_valid & ~ack;
               seen++;
            end
         end
         req_valid = '0;
         @(posedge clock); #1;
         n_checks++;
         if (got[0] !== 2'b01 || got[1] !== 2'b10 || edge_at[0] !== 2 || edge_at[1] !== 5) begin
            n_fail++;
            $display("FAIL rr_order_%0d: acks=%b,%b at edges %0d,%0d, required 01,10 at 2,5",
                     round, got[0], got[1], edge_at[0], edge_at[1]);
         end
         n_checks++;
         if (got_err[0] !== 1'b0 || got_err[1] !== 1'b0 ||
             got_arr[0] !== 12'd0 || got_arr[1] !== ((round == 0) ? 12'd1 : 12'd0)) begin
            n_fail++;
            $display("FAIL rr_result_%0d: arr=%0d,%0d err=%b,%b, required arr=0,%0d err=0,0",
                     round, got_arr[0], got_arr[1], got_err[0], got_err[1], (round == 0) ? 1 : 0);
         end
      end
      n_checks++;
      if (in_use !== 12'd0 || high_water !== 12'd2) begin
         n_fail++;
         $display("FAIL rr_counts: in_use=%0d hw=%0d, required in_use=0 hw=2", in_use, high_water);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] a; logic [11:0] arr, idx; logic err, clr; int lat;
      logic stray;
      req_valid[0] = 1'b1; req_free[0] = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({ack, ack_array, ack_error, size_clear, size_index, in_use, high_water} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: ack=%b arr=%0d err=%b clr=%b idx=%0d in_use=%0d hw=%0d, required all 0",
                  ack, ack_array, ack_error, size_clear, size_index, in_use, high_water);
      end
      req_valid = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      stray = 1'b0;
      repeat (4) begin
         @(posedge clock); #1;
         if (ack != 2'b00) stray = 1'b1;
      end
      n_checks++;
      if (stray !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stale_ack: stray ack seen=%b, required 0", stray);
      end
      run_op(0, 1'b0, 12'd0, a, arr, err, clr, idx, lat);
      n_checks++;
      if (a !== 2'b01 || lat !== 2 || arr !== 12'd0 || err !== 1'b0 || high_water !== 12'd1) begin
         n_fail++;
         $display("FAIL reset_realloc: ack=%b lat=%0d arr=%0d err=%b hw=%0d, required ack=01 lat=2 arr=0 err=0 hw=1",
                  a, lat, arr, err, high_water);
      end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_exhaust();
      test_lifo();
      test_double_free();
      test_rr();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
